// File: rtl/prim_edge_event_pkg.sv
// Shared types for the edge/long-hold event generator.
// Latency: n/a (declarations only).
// Backpressure: none; the block has no flow control.
package prim_edge_event_pkg;

  // Long-hold tracking states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    HELD   = 2'd2
  } hold_state_e;

  // Bit positions inside the sticky status vector.
  localparam int unsigned STATUS_RISE = 0;
  localparam int unsigned STATUS_FALL = 1;
  localparam int unsigned STATUS_HOLD = 2;
  localparam int unsigned STATUS_W    = 3;

endpackage

// File: rtl/prim_edge_event_sat_cnt.sv
// Saturating up-counter with clear taking priority over increment.
// Latency: count visible the cycle after the increment request is sampled.
// Backpressure: none; increments beyond all-ones are dropped (saturation).
module prim_edge_event_sat_cnt
  import prim_edge_event_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step up unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prim_edge_event.sv
// Edge / long-hold event generator for filtered slow inputs; hold logic under PRIM_EDGE_EVENT_HOLD_EN.
// Latency: rise/fall pulse 1 cycle after the edge sample, hold pulse HoldCycles-1 cycles after rise.
// Backpressure: none; pulses are single-cycle, status is sticky until cleared.
module prim_edge_event
  import prim_edge_event_pkg::*;
#(
  parameter int unsigned HoldCycles = 16,
  parameter int unsigned CntWidth   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                level_i,
  input  logic                cnt_clr_i,
  input  logic [STATUS_W-1:0] status_clr_i,
  output logic                rise_o,
  output logic                fall_o,
  output logic                hold_o,
  output logic [CntWidth-1:0] edge_cnt_o,
  output logic [STATUS_W-1:0] status_o
);

  logic level_q;
  // Low for the first cycle after reset so the level present at release
  // becomes the baseline instead of being reported as an edge.
  logic armed_q;
  logic rise_d, fall_d, hold_d;
  logic rise_q, fall_q, hold_q;
  logic [STATUS_W-1:0] pulses;
  logic [STATUS_W-1:0] status_q, status_d;

  // Level history tracks the input regardless of enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      level_q <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_d = armed_q & enable_i &  level_i & ~level_q;
  assign fall_d = armed_q & enable_i & ~level_i &  level_q;

`ifdef PRIM_EDGE_EVENT_HOLD_EN
  localparam int unsigned TimerW = (HoldCycles > 2) ? $clog2(HoldCycles) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(HoldCycles - 1);

  hold_state_e       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;

  // Hold FSM next state: count consecutive enabled high samples after a rise.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hold_d  = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_d) begin
            state_d = TIMING;
            timer_d = TimerW'(1);
          end
        end
        TIMING: begin
          if (!level_i) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_q == TimerLast) begin
            hold_d  = 1'b1;
            state_d = HELD;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        HELD: begin
          // Only a fresh rise (via IDLE) can re-arm the hold.
          if (!level_i) begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Hold FSM state and timer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end
`else
  // Hold detection absent: the hold length parameter has no effect.
  logic unused_hold_cfg;
  assign unused_hold_cfg = ^HoldCycles;
  assign hold_d = 1'b0;
`endif

  // Register the detect terms into single-cycle pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      hold_q <= hold_d;
    end
  end

  // Gather the currently visible pulses into status bit order.
  always_comb begin
    pulses              = '0;
    pulses[STATUS_RISE] = rise_q;
    pulses[STATUS_FALL] = fall_q;
    pulses[STATUS_HOLD] = hold_q;
  end

  // Sticky status: a coincident set beats the clear so no event is lost.
  always_comb begin
    status_d = (status_q & ~status_clr_i) | pulses;
  end

  // Status register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  prim_edge_event_sat_cnt #(
    .Width (CntWidth)
  ) u_edge_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (cnt_clr_i),
    .inc_i (rise_d | fall_d),
    .cnt_o (edge_cnt_o)
  );

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign hold_o   = hold_q;
  assign status_o = status_q;

endmodule

// File: tb/tb_prim_edge_event.sv
// Scoreboard bench for prim_edge_event (hold checks follow PRIM_EDGE_EVENT_HOLD_EN).
// Latency: reference model predicts outputs for each clock edge; monitor compares at the falling edge.
// Backpressure: none; one expected entry per clock.
module tb_prim_edge_event;

  localparam int unsigned HC = 4;
  localparam int unsigned CW = 3;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          level_i;
  logic          cnt_clr_i;
  logic [2:0]    status_clr_i;
  logic          rise_o, fall_o, hold_o;
  logic [CW-1:0] edge_cnt_o;
  logic [2:0]    status_o;

  always #5 clk_i = ~clk_i;

  prim_edge_event #(
    .HoldCycles (HC),
    .CntWidth   (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .level_i      (level_i),
    .cnt_clr_i    (cnt_clr_i),
    .status_clr_i (status_clr_i),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .hold_o       (hold_o),
    .edge_cnt_o   (edge_cnt_o),
    .status_o     (status_o)
  );

  typedef struct {
    int r;
    int f;
    int h;
    int c;
    int s;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_hold_seen = 0;

  // Reference model state, in terms of the observable behaviour.
  int m_prev;
  int m_first;
  int m_run;
  int m_cnt;
  int m_stat;
  int m_r, m_f, m_h;

  // Predict the outputs visible after each rising edge.
  always @(posedge clk_i) begin
    int r, f, h;
    exp_t e;
    if (rst_i) begin
      m_prev = 0; m_first = 1; m_run = 0; m_cnt = 0; m_stat = 0;
      m_r = 0; m_f = 0; m_h = 0;
    end else begin
      r = (m_first == 0 && enable_i && level_i && m_prev == 0) ? 1 : 0;
      f = (m_first == 0 && enable_i && !level_i && m_prev == 1) ? 1 : 0;
      // Pulses showing before this edge become sticky; a set beats a clear.
      m_stat = (m_stat & ~int'(status_clr_i)) | (m_h << 2) | (m_f << 1) | m_r;
      // Length of the current enabled-high run that began with a rise.
      if (!enable_i || !level_i) m_run = 0;
      else if (r == 1)           m_run = 1;
      else if (m_run > 0)        m_run = m_run + 1;
`ifdef PRIM_EDGE_EVENT_HOLD_EN
      h = (m_run == HC) ? 1 : 0;
`else
      h = 0;
`endif
      if (cnt_clr_i)                       m_cnt = 0;
      else if ((r | f) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_prev = level_i ? 1 : 0;
      m_first = 0;
      m_r = r; m_f = f; m_h = h;
    end
    e.r = m_r; e.f = m_f; e.h = m_h; e.c = m_cnt; e.s = m_stat;
    exp_q.push_back(e);
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rise_o",     int'(rise_o),     e.r);
      check("fall_o",     int'(fall_o),     e.f);
      check("hold_o",     int'(hold_o),     e.h);
      check("edge_cnt_o", int'(edge_cnt_o), e.c);
      check("status_o",   int'(status_o),   e.s);
      if (hold_o) n_hold_seen++;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int runleft;
    rst_i = 1'b1; enable_i = 1'b0; level_i = 1'b0; cnt_clr_i = 1'b0; status_clr_i = 3'b000;
    step(3);
    rst_i = 1'b0; enable_i = 1'b1;

    // Short pulse: rise then fall, no hold.
    step(10);
    level_i = 1'b1; step(2);
    level_i = 1'b0; step(6);

    // Long hold, then release and clear all status.
    level_i = 1'b1; step(10);
    level_i = 1'b0; step(3);
    status_clr_i = 3'b111; step(1);
    status_clr_i = 3'b000; step(2);

    // Saturation after 9 toggles, then clear coincident with an edge.
    cnt_clr_i = 1'b1; step(1); cnt_clr_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      level_i = ~level_i; step(1);
    end
    step(2);
    level_i = ~level_i; cnt_clr_i = 1'b1; step(1);
    cnt_clr_i = 1'b0; level_i = 1'b0; step(3);

    // Status clear colliding with the rise pulse, then a plain clear.
    status_clr_i = 3'b111; step(1); status_clr_i = 3'b000;
    level_i = 1'b1; step(1);
    status_clr_i = 3'b001; step(1);
    status_clr_i = 3'b000; step(1);
    status_clr_i = 3'b001; step(1);
    status_clr_i = 3'b000; level_i = 1'b0; step(3);

    // Enable low across the rise, re-enabled with level still high.
    enable_i = 1'b0; step(1);
    level_i = 1'b1; step(2);
    enable_i = 1'b1; step(8);
    level_i = 1'b0; step(2);
    // Enable dropped mid-timing.
    level_i = 1'b1; step(2);
    enable_i = 1'b0; step(1);
    enable_i = 1'b1; step(8);
    level_i = 1'b0; step(2);

    // Reset with input high: no rise after release, fall later.
    level_i = 1'b1; step(2);
    rst_i = 1'b1; step(2);
    rst_i = 1'b0; step(6);
    level_i = 1'b0; step(3);

    // Randomized traffic.
    runleft = 0;
    for (int i = 0; i < 3000; i++) begin
      if (runleft == 0) begin
        level_i = ~level_i;
        runleft = $urandom_range(1, 7);
      end
      runleft--;
      enable_i     = ($urandom_range(0, 9) != 0);
      cnt_clr_i    = ($urandom_range(0, 31) == 0);
      status_clr_i = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rst_i        = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst_i = 1'b0; enable_i = 1'b1; cnt_clr_i = 1'b0; status_clr_i = 3'b000;
    step(2);
    @(negedge clk_i);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef PRIM_EDGE_EVENT_HOLD_EN
    check("hold_pulses_present", (n_hold_seen > 0) ? 1 : 0, 1);
`else
    check("hold_pulses_absent", n_hold_seen, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
